cim_result_collector: RTL
=========================

// Module: cim_result_collector
// PURPOSE
//  Downstream stage of the CIM macro top level. Detects completion of each
//  accumulation on st and captures the 51-bit nout result into a small FIFO.
//  Drains results to the host/readout bus over a valid/ready stream, and
//  reports overflow.
// PARAMETERS
//  DATA_W   51  width of captured result; must equal the macro's nout width
//  DEPTH    8   FIFO entries; power of two, 2..64
//  CNT_W    8   width of the saturating drop counter
// PORTS
//  clk       in   1          system clock, all logic on rising edge
//  rstn      in   1          asynchronous active-low reset
//  nout      in   DATA_W     accumulated result from the CIM macro
//  st        in   1          macro accumulator status; 0->1 edge = result ready
//  cima      in   1          bank select in use by the macro (tag source)
//  cap_en    in   1          1 = capture enabled; 0 = ignore st edges
//  m_data    out  DATA_W     head-of-FIFO result
//  m_valid   out  1          m_data valid
//  m_ready   in   1          consumer accepts m_data when m_valid&m_ready
//  m_tag     out  1          bank tag of head entry (only with CIM_RESULT_TAG_EN)
//  count     out  $clog2(DEPTH)+1  entries currently held
//  full      out  1          count==DEPTH
//  empty     out  1          count==0
//  ovf       out  1          sticky: a capture was dropped
//  ovf_clr   in   1          synchronous clear of ovf and drop_cnt
//  drop_cnt  out  CNT_W      number of dropped captures, saturating at all-ones
// BEHAVIOUR
//  - Reset (async, rstn=0): st_d=0, wr/rd pointers=0, count=0, empty=1, full=0,
//    m_valid=0, ovf=0, drop_cnt=0, m_tag=0. m_data is don't-care while m_valid=0.
//  - Edge detect: st_d registers st each cycle. cap = cap_en & st & ~st_d.
//    st held high for many cycles yields exactly one capture.
//  - Push: on a cycle with cap=1 and the FIFO accepting, nout (and cima) present
//    that same cycle are written at wr_ptr. wr_ptr wraps modulo DEPTH.
//  - Pop: a cycle with m_valid&m_ready advances rd_ptr. rd_ptr wraps modulo DEPTH.
//  - Read-port timing: m_data=mem[rd_ptr], driven combinationally from storage;
//    m_valid = ~empty.
//  - Latency: a capture into an empty FIFO gives m_valid=1 on the next cycle.
//  - Handshake: once m_valid=1, m_data and m_tag stay stable until accepted.
//    m_valid never drops without a pop.
//  - Simultaneous push and pop:
//    - count unchanged.
//    - When full, the pop frees the slot and the push is accepted (no drop).
//    - When empty, no pop can occur, since m_valid=0.
//  - Full without pop:
//    - cap is dropped and memory is unchanged.
//    - ovf<=1; drop_cnt increments, saturating at 2^CNT_W-1.
//  - ovf_clr:
//    - Clears ovf and drop_cnt next cycle.
//    - A drop in the same cycle wins: ovf=1, drop_cnt=1.
//  - cap_en: deasserting cap_en mid-stream does not flush the FIFO.
//    st_d keeps tracking st, so re-enabling while st=1 does not capture.
//  - Reset mid-operation: all contents discarded; state returns to reset values
//    immediately.
//  - Data is stored verbatim (no sign handling); width rule is DATA_W-bit copy.
// CONFIGURATION
//  CIM_RESULT_TAG_EN defined:
//    - Each entry stores {cima, nout}. m_tag outputs the head entry's cima.
//    - m_tag resets to 0 and is valid with m_valid.
//  CIM_RESULT_TAG_EN undefined:
//    - No tag storage and no m_tag port; entries are DATA_W bits.
// TESTING
//  1 Reset: rstn=0 mid-run with count=3 -> count=0, empty=1, m_valid=0,
//    ovf=0, drop_cnt=0.
//  2 Single capture: nout=51'h1_2345_6789_ABCD, st 0->1 held 5 cycles,
//    m_ready=0 -> one entry; m_valid=1 one cycle after edge; m_data holds value.
//  3 Fill/overflow: 10 st pulses (DEPTH=8), m_ready=0 -> full=1, count=8,
//    ovf=1, drop_cnt=2; drain gives first 8 values in order.
//  4 Full with simultaneous pop+capture: count=8, m_ready=1 on edge cycle
//    -> count stays 8, no drop, ovf=0, new value is last out.
//  5 ovf_clr: after scenario 3, pulse ovf_clr -> ovf=0, drop_cnt=0.
//    Pulse ovf_clr on a drop cycle -> ovf=1, drop_cnt=1.
//  6 Tag (CIM_RESULT_TAG_EN): captures with cima=0,1,1 -> m_tag reads 0,1,1
//    across pops. cap_en=0 pulse -> no entry added.

Source files
------------

// File: rtl/cim_result_collector.sv
// Result collector for the CIM macro: captures nout on each rising edge of st into a FIFO and drains it over valid/ready.
// Optional feature: define CIM_RESULT_TAG_EN to store the bank select (cima) with each entry and expose it on m_tag.
module cim_result_collector #(
  parameter int DATA_W = 51,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DATA_W-1:0]          nout,
  input  logic                       st,
  input  logic                       cima,
  input  logic                       cap_en,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
`ifdef CIM_RESULT_TAG_EN
  output logic                       m_tag,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
`ifdef CIM_RESULT_TAG_EN
  localparam int ENT_W = DATA_W + 1;
`else
  localparam int ENT_W = DATA_W;
`endif
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             st_d;
  logic             cap;
  logic             pop;
  logic             push;
  logic             drop;
  logic [ENT_W-1:0] wr_ent;
  logic [ENT_W-1:0] head;

`ifdef CIM_RESULT_TAG_EN
  assign wr_ent = {cima, nout};
`else
  logic cima_unused;
  assign cima_unused = cima;
  assign wr_ent      = nout;
`endif

  // Stage 0: edge detect and push/pop/drop decisions for this cycle.
  assign cap  = cap_en & st & ~st_d;
  assign pop  = m_valid & m_ready;
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign m_valid = ~empty;
  assign head    = mem[rd_ptr];
  assign m_data  = head[DATA_W-1:0];
`ifdef CIM_RESULT_TAG_EN
  assign m_tag   = m_valid & head[DATA_W];
`endif

  // Stage 1: control state update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_d     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      st_d <= st;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        ovf      <= 1'b1;
        drop_cnt <= ovf_clr ? CNT_W'(1) : sat_inc(drop_cnt);
      end else if (ovf_clr) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

endmodule
